async_fifo_wr_ctrl: RTL and testbench

//  Write-domain controller of the async FIFO; sits directly upstream of the dual-clock BRAM.

---
 rtl/async_fifo_wr_ctrl.sv | 170 +++++++++++++++++
 tb/tb_async_fifo_wr_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: handshake intake, BRAM write port, Gray pointer exchange, full/overflow.
// Optional ASYNC_FIFO_WR_LEVEL_EN adds a registered wr_level output (fill level as seen from the write side).
module async_fifo_wr_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SIZE        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wr_clk,
  input  logic              wr_rst,
  input  logic [WIDTH:0]    s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [WIDTH:0]    data_in,
  output logic [SIZE:0]     wrt_ptr,
  output logic [SIZE:0]     wr_ptr_gray,
  input  logic [SIZE:0]     rd_ptr_gray,
  output logic              full,
  output logic              overflow
`ifdef ASYNC_FIFO_WR_LEVEL_EN
  ,
  output logic [SIZE:0]     wr_level
`endif
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SIZE:0] PTR_ZERO  = {(SIZE+1){1'b0}};
  localparam logic [SIZE:0] PTR_ONE   = {{SIZE{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [SIZE:0] bin2gray(input logic [SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [SIZE:0] gray2bin(input logic [SIZE:0] g);
    logic [SIZE:0] b;
    b[SIZE] = g[SIZE];
    for (int i = SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [SIZE:0] wbin_r;
  logic [SIZE:0] wgray_r;
  logic [SIZE:0] sync_r [SYNC_STAGES];
  logic          full_r;
  logic          overflow_r;
  logic          s_ready_s;
  logic          accept_s;
  logic [SIZE:0] wbin_next_s;
  logic [SIZE:0] gnext_s;
  logic [SIZE:0] rq_s;
  logic          full_match_s;
  logic          overflow_set_s;

  // Next-state and handshake decode; reset gates the handshake so an in-flight accept is dropped.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    s_ready_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == INIT_LAST) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    if ((state_r == ST_RUN) && !wr_rst) begin
      s_ready_s = ~full_r;
    end else begin
      s_ready_s = 1'b0;
    end
  end

  // Pointer arithmetic and the full comparison against the synchronised read pointer.
  always_comb begin
    accept_s       = s_valid & s_ready_s;
    wbin_next_s    = accept_s ? (wbin_r + PTR_ONE) : wbin_r;
    gnext_s        = bin2gray(wbin_next_s);
    rq_s           = sync_r[SYNC_STAGES-1];
    full_match_s   = (gnext_s == {~rq_s[SIZE:SIZE-1], rq_s[SIZE-2:0]});
    overflow_set_s = (state_r == ST_RUN) & s_valid & ~s_ready_s;
  end

  // FSM state and INIT flush counter.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_r <= ST_INIT;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Read-pointer synchroniser chain; rq is always taken from its last stage.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= PTR_ZERO;
      end
    end else begin
      sync_r[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Write pointers, full and sticky overflow.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin_r     <= PTR_ZERO;
      wgray_r    <= PTR_ZERO;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wbin_r     <= wbin_next_s;
      wgray_r    <= gnext_s;
      full_r     <= full_match_s;
      overflow_r <= overflow_r | overflow_set_s;
    end
  end

`ifdef ASYNC_FIFO_WR_LEVEL_EN
  logic [SIZE:0] level_r;

  // Fill level from the write side, pessimistic by the synchroniser latency.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      level_r <= PTR_ZERO;
    end else if (state_r == ST_INIT) begin
      level_r <= PTR_ZERO;
    end else begin
      level_r <= wbin_next_s - gray2bin(rq_s);
    end
  end

  assign wr_level = level_r;
`endif

  assign s_ready     = s_ready_s;
  assign wr_en       = accept_s;
  assign data_in     = s_data;
  assign wrt_ptr     = wbin_r;
  assign wr_ptr_gray = wgray_r;
  assign full        = full_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed self-checking bench for async_fifo_wr_ctrl (default parameters; honours ASYNC_FIFO_WR_LEVEL_EN).
module tb_async_fifo_wr_ctrl;

  localparam int WIDTH = 8;
  localparam int SIZE  = 8;

  logic            wr_clk = 1'b0;
  logic            wr_rst;
  logic [WIDTH:0]  s_data;
  logic            s_valid;
  logic            s_ready;
  logic            wr_en;
  logic [WIDTH:0]  data_in;
  logic [SIZE:0]   wrt_ptr;
  logic [SIZE:0]   wr_ptr_gray;
  logic [SIZE:0]   rd_ptr_gray;
  logic            full;
  logic            overflow;
`ifdef ASYNC_FIFO_WR_LEVEL_EN
  logic [SIZE:0]   wr_level;
`endif

  int checks   = 0;
  int failures = 0;
  logic [SIZE:0] exp_wbin;
  logic [SIZE:0] rbin;

  async_fifo_wr_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .SYNC_STAGES(2)) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .wrt_ptr     (wrt_ptr),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .full        (full),
    .overflow    (overflow)
`ifdef ASYNC_FIFO_WR_LEVEL_EN
    ,
    .wr_level    (wr_level)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [SIZE:0] g(input logic [SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic reader_step();
    if (rbin != exp_wbin) rbin = rbin + 9'd1;
    rd_ptr_gray = g(rbin);
  endtask

  // n back-to-back accepts, each expected to be taken immediately.
  task automatic stream(input int n, input bit chk_gray, input bit track);
    logic [SIZE:0] prev;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = exp_wbin ^ 9'h0A5;
      @(negedge wr_clk);
      check_eq("acc_ready", s_ready, 1'b1);
      check_eq("acc_wr_en", wr_en, 1'b1);
      check_eq("acc_ptr", wrt_ptr, exp_wbin);
      check_eq("acc_data", data_in, exp_wbin ^ 9'h0A5);
      check_eq("acc_nofull", full, 1'b0);
      prev = wr_ptr_gray;
      tick();
      exp_wbin = exp_wbin + 9'd1;
      check_eq("acc_gray", wr_ptr_gray, g(exp_wbin));
      if (chk_gray) check_eq("gray_1bit", $countones(prev ^ wr_ptr_gray), 32'd1);
      if (track) reader_step();
    end
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int i = 0; i < 600 && rbin != exp_wbin; i++) begin
      reader_step();
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic do_reset(input logic valid);
    s_valid     = valid;
    wr_rst      = 1'b1;
    rd_ptr_gray = 9'd0;
    rbin        = 9'd0;
    exp_wbin    = 9'd0;
    tick();
    wr_rst = 1'b0;
  endtask

  initial begin
    wr_rst      = 1'b1;
    s_valid     = 1'b0;
    s_data      = 9'd0;
    rd_ptr_gray = 9'd0;
    exp_wbin    = 9'd0;
    rbin        = 9'd0;
    tick();

    // 1: reset with s_valid high, INIT flush of 3 cycles
    do_reset(1'b1);
    check_eq("rst_ptr", wrt_ptr, 9'd0);
    check_eq("rst_gray", wr_ptr_gray, 9'd0);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge wr_clk);
      check_eq("init_ready", s_ready, 1'b0);
      check_eq("init_wr_en", wr_en, 1'b0);
`ifdef ASYNC_FIFO_WR_LEVEL_EN
      check_eq("init_level", wr_level, 9'd0);
`endif
      tick();
    end

    // 2: fill 256 words with the reader idle
    stream(256, 1'b0, 1'b0);
    check_eq("fill_full", full, 1'b1);
    check_eq("fill_ready", s_ready, 1'b0);
    check_eq("fill_gray", wr_ptr_gray, 9'h180);
    check_eq("fill_ptr", wrt_ptr, 9'd256);
`ifdef ASYNC_FIFO_WR_LEVEL_EN
    check_eq("fill_level", wr_level, 9'd256);
`endif
    @(negedge wr_clk);
    check_eq("full_no_wr", wr_en, 1'b0);
    tick();
    check_eq("full_ovf", overflow, 1'b1);
    check_eq("full_ptr_hold", wrt_ptr, 9'd256);
    s_valid = 1'b0;

    // 3: one read clears full after exactly three edges
    rbin        = 9'd1;
    rd_ptr_gray = 9'h001;
    tick();
    check_eq("clr_c1", full, 1'b1);
    tick();
    check_eq("clr_c2", full, 1'b1);
    tick();
    check_eq("clr_c3", full, 1'b0);
    s_valid = 1'b1;
    s_data  = 9'h155;
    @(negedge wr_clk);
    check_eq("refill_wr_en", wr_en, 1'b1);
    check_eq("refill_ptr", wrt_ptr, 9'd256);
    tick();
    s_valid  = 1'b0;
    exp_wbin = 9'd257;
    check_eq("refill_full", full, 1'b1);
    check_eq("refill_gray", wr_ptr_gray, 9'h181);

    // 4: drain, then stream 600 words with a tracking reader (wraps 511->0)
    drain();
    check_eq("drain_full", full, 1'b0);
    stream(600, 1'b1, 1'b1);
    check_eq("wrap_ptr", wrt_ptr, 9'd345);
    s_valid = 1'b0;

    // 5: refill from reset, then hold s_valid while full
    do_reset(1'b0);
    check_eq("r5_ovf", overflow, 1'b0);
    repeat (3) tick();
    stream(256, 1'b0, 1'b0);
    check_eq("f5_full", full, 1'b1);
    check_eq("f5_ovf_clear", overflow, 1'b0);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      @(negedge wr_clk);
      check_eq("ovf_no_wr", wr_en, 1'b0);
      check_eq("ovf_ptr", wrt_ptr, 9'd256);
      tick();
    end
    check_eq("ovf_set", overflow, 1'b1);
    s_valid = 1'b0;
    repeat (3) tick();
    check_eq("ovf_sticky", overflow, 1'b1);

    // 6: reach wrt_ptr=100 while streaming, then reset during an accept
    drain();
    stream(356, 1'b0, 1'b1);
    check_eq("pre_rst_ptr", wrt_ptr, 9'd100);
    check_eq("pre_rst_ovf", overflow, 1'b1);
    s_valid     = 1'b1;
    wr_rst      = 1'b1;
    rd_ptr_gray = 9'd0;
    @(negedge wr_clk);
    check_eq("rst_no_wr", wr_en, 1'b0);
    check_eq("rst_ptr_hold", wrt_ptr, 9'd100);
    tick();
    wr_rst = 1'b0;
    check_eq("post_rst_ptr", wrt_ptr, 9'd0);
    check_eq("post_rst_gray", wr_ptr_gray, 9'd0);
    check_eq("post_rst_full", full, 1'b0);
    check_eq("post_rst_ovf", overflow, 1'b0);
    check_eq("post_rst_ready", s_ready, 1'b0);
`ifdef ASYNC_FIFO_WR_LEVEL_EN
    check_eq("post_rst_level", wr_level, 9'd0);
`endif
    s_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
